// File: rtl/avmm_lsu_pkg.sv
// Shared types, FSM state encodings and lane helpers for the schoolMIPS Avalon-MM LSU master.
package avmm_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t REQ     = 2'd1;
  localparam state_t WAIT_RD = 2'd2;
  localparam state_t RESP    = 2'd3;

  function automatic logic [3:0] calc_byteenable(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Size encoding 3 is illegal and reported through the same error path as misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b1;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/avmm_lsu_master_lane_align.sv
// Combinational lane steering: byteenable and write replication, load extraction and extension.
module avmm_lane_align
  import avmm_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o    = calc_byteenable(size_i, addr_lo_i);
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    wdata_o = wdata_i;
    rdata_o = shifted;
    case (size_i)
      SZ_BYTE: begin
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        wdata_o = wdata_i;
        rdata_o = shifted;
      end
    endcase
  end

endmodule

// File: rtl/avmm_lsu_master.sv
// Avalon-MM master for schoolMIPS byte/half/word loads and stores, one transaction in flight.
// Optional watchdog enabled by defining AVM_TIMEOUT_EN.
module avmm_lsu_master
  import avmm_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [1:0]        cmd_size_i,
  input  logic              cmd_signed_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [31:0]       cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_error_o,
  output logic [ADDR_W-1:0] avm_address_o,
  output logic [3:0]        avm_byteenable_o,
  output logic              avm_write_o,
  output logic              avm_read_o,
  output logic [31:0]       avm_writedata_o,
  input  logic [31:0]       avm_readdata_i,
  input  logic              avm_waitrequest_i,
  input  logic              avm_readdatavalid_i
);

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] avm_address_q, avm_address_d;
  logic [3:0]        avm_be_q, avm_be_d;
  logic              avm_write_q, avm_write_d;
  logic              avm_read_q, avm_read_d;
  logic [31:0]       avm_wdata_q, avm_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;

  logic [1:0]  align_size;
  logic [1:0]  align_addr_lo;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_rdata;

  // Lane logic sees the live command while idle and the registered one afterwards.
  assign align_size    = (state_q == IDLE) ? cmd_size_i : size_q;
  assign align_addr_lo = (state_q == IDLE) ? cmd_addr_i[1:0] : addr_lo_q;

  avmm_lane_align u_lane_align (
    .size_i    (align_size),
    .addr_lo_i (align_addr_lo),
    .signed_i  (signed_q),
    .wdata_i   (cmd_wdata_i),
    .rdata_i   (avm_readdata_i),
    .be_o      (align_be),
    .wdata_o   (align_wdata),
    .rdata_o   (align_rdata)
  );

`ifdef AVM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 256) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_hit;
  assign timeout_hit = ((state_q == REQ) || (state_q == WAIT_RD)) &&
                       (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    size_d        = size_q;
    signed_d      = signed_q;
    addr_lo_d     = addr_lo_q;
    err_d         = err_q;
    rdata_d       = rdata_q;
    avm_address_d = avm_address_q;
    avm_be_d      = avm_be_q;
    avm_write_d   = avm_write_q;
    avm_read_d    = avm_read_q;
    avm_wdata_d   = avm_wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_error_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          write_d   = cmd_write_i;
          size_d    = cmd_size_i;
          signed_d  = cmd_signed_i;
          addr_lo_d = cmd_addr_i[1:0];
          rdata_d   = '0;
          if (is_misaligned(cmd_size_i, cmd_addr_i[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d         = 1'b0;
            avm_address_d = {cmd_addr_i[ADDR_W-1:2], 2'b00};
            avm_be_d      = align_be;
            avm_wdata_d   = align_wdata;
            avm_write_d   = cmd_write_i;
            avm_read_d    = ~cmd_write_i;
            state_d       = REQ;
          end
        end
      end
      REQ: begin
        if (!avm_waitrequest_i) begin
          avm_write_d = 1'b0;
          avm_read_d  = 1'b0;
          state_d     = write_q ? RESP : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (avm_readdatavalid_i) begin
          rdata_d = align_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = err_q ? 32'h0 : rdata_q;
        rsp_error_d = err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef AVM_TIMEOUT_EN
    if (timeout_hit) begin
      avm_write_d = 1'b0;
      avm_read_d  = 1'b0;
      err_d       = 1'b1;
      rdata_d     = '0;
      state_d     = RESP;
    end
    cnt_d = cnt_q;
    if ((state_d != state_q) && ((state_d == REQ) || (state_d == WAIT_RD))) begin
      cnt_d = '0;
    end else if ((state_q == REQ) || (state_q == WAIT_RD)) begin
      cnt_d = cnt_q + CntW'(1);
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      size_q        <= 2'b00;
      signed_q      <= 1'b0;
      addr_lo_q     <= 2'b00;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      avm_address_q <= '0;
      avm_be_q      <= '0;
      avm_write_q   <= 1'b0;
      avm_read_q    <= 1'b0;
      avm_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      addr_lo_q     <= addr_lo_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      avm_address_q <= avm_address_d;
      avm_be_q      <= avm_be_d;
      avm_write_q   <= avm_write_d;
      avm_read_q    <= avm_read_d;
      avm_wdata_q   <= avm_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
    end
  end

`ifdef AVM_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign cmd_ready_o      = (state_q == IDLE);
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_rdata_o      = rsp_rdata_q;
  assign rsp_error_o      = rsp_error_q;
  assign avm_address_o    = avm_address_q;
  assign avm_byteenable_o = avm_be_q;
  assign avm_write_o      = avm_write_q;
  assign avm_read_o       = avm_read_q;
  assign avm_writedata_o  = avm_wdata_q;

endmodule

// File: tb/tb_avmm_lsu_master.sv
// Scoreboard bench for avmm_lsu_master; timeout scenario runs when AVM_TIMEOUT_EN is defined.
module tb_avmm_lsu_master;

  logic        clock = 1'b0;
  logic        resetn;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_signed;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic [3:0]  avm_byteenable;
  logic        avm_write, avm_read, avm_waitrequest, avm_readdatavalid;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  avmm_lsu_master #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock               (clock),
    .resetn              (resetn),
    .cmd_valid_i         (cmd_valid),
    .cmd_ready_o         (cmd_ready),
    .cmd_write_i         (cmd_write),
    .cmd_size_i          (cmd_size),
    .cmd_signed_i        (cmd_signed),
    .cmd_addr_i          (cmd_addr),
    .cmd_wdata_i         (cmd_wdata),
    .rsp_valid_o         (rsp_valid),
    .rsp_rdata_o         (rsp_rdata),
    .rsp_error_o         (rsp_error),
    .avm_address_o       (avm_address),
    .avm_byteenable_o    (avm_byteenable),
    .avm_write_o         (avm_write),
    .avm_read_o          (avm_read),
    .avm_writedata_o     (avm_writedata),
    .avm_readdata_i      (avm_readdata),
    .avm_waitrequest_i   (avm_waitrequest),
    .avm_readdatavalid_i (avm_readdatavalid)
  );

  // Scoreboard: every response pulse pops one expectation.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (rsp_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: rdata=%h err=%b with nothing outstanding", rsp_rdata, rsp_error);
      end else begin
        e = sb.pop_front();
        if (rsp_rdata !== e.rdata || rsp_error !== e.err) begin
          errors++;
          $display("FAIL rsp_data: got rdata=%h err=%b, want rdata=%h err=%b",
                   rsp_rdata, rsp_error, e.rdata, e.err);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Drives a command in the current (idle) cycle; returns in the cycle after acceptance.
  task automatic send_cmd(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input bit push);
    exp_t e;
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_size   = sz;
    cmd_signed = sg;
    cmd_addr   = addr;
    cmd_wdata  = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    if (push) sb.push_back(e);
    step;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output bit seen, output int n);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < max) begin
      step;
      n++;
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    step;
    step;
    checks++;
    if ({rsp_valid, rsp_error, rsp_rdata, avm_write, avm_read, avm_byteenable, avm_address,
         avm_writedata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rv=%b re=%b rd=%h w=%b r=%b be=%h a=%h wd=%h, want all 0",
               rsp_valid, rsp_error, rsp_rdata, avm_write, avm_read, avm_byteenable,
               avm_address, avm_writedata);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
    resetn = 1'b1;
    step;
  endtask

  task automatic test_sw;
    send_cmd(1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    checks++;
    if (avm_write !== 1'b1 || avm_read !== 1'b0 || avm_byteenable !== 4'hF ||
        avm_address !== 32'h1000 || avm_writedata !== 32'hDEADBEEF || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL sw_bus: w=%b r=%b be=%h a=%h wd=%h rdy=%b, want 1 0 f 00001000 deadbeef 0",
               avm_write, avm_read, avm_byteenable, avm_address, avm_writedata, cmd_ready);
    end
    step;
    checks++;
    if (avm_write !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sw_cycle2: w=%b rv=%b, want 0 0", avm_write, rsp_valid);
    end
    step;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL sw_latency: rsp_valid=%b at accept+3, want 1", rsp_valid);
    end
    step;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL sw_after: rv=%b rdy=%b, want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_sb;
    bit seen;
    int n;
    send_cmd(1'b1, 2'd0, 1'b0, 32'h1003, 32'h000000A5, 32'h0, 1'b0, 1'b1);
    checks++;
    if (avm_write !== 1'b1 || avm_byteenable !== 4'b1000 || avm_address !== 32'h1000 ||
        avm_writedata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL sb_bus: w=%b be=%b a=%h wd=%h, want 1 1000 00001000 a5a5a5a5",
               avm_write, avm_byteenable, avm_address, avm_writedata);
    end
    wait_rsp(10, seen, n);
    checks++;
    if (!seen || n != 2) begin
      errors++;
      $display("FAIL sb_latency: seen=%b cycles=%0d, want seen=1 cycles=2", seen, n);
    end
    step;
  endtask

  logic [31:0] ld_addr[6] = '{32'h2002, 32'h2002, 32'h2001, 32'h2003, 32'h2004, 32'h2000};
  logic [1:0]  ld_size[6] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd1};
  logic        ld_sgn[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [3:0]  ld_be[6]   = '{4'b1100, 4'b1100, 4'b0010, 4'b1000, 4'b1111, 4'b0011};
  logic [31:0] ld_exp[6]  = '{32'hFFFF8001, 32'h00008001, 32'h00000012, 32'hFFFFFF80,
                              32'h80011234, 32'h00001234};

  task automatic test_loads;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        // Stray readdatavalid during acceptance must not be captured.
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hFFFFFFFF;
      end
      send_cmd(1'b0, ld_size[i], ld_sgn[i], ld_addr[i], 32'h0, ld_exp[i], 1'b0, 1'b1);
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'h0;
      checks++;
      if (avm_read !== 1'b1 || avm_write !== 1'b0 || avm_byteenable !== ld_be[i] ||
          avm_address !== {ld_addr[i][31:2], 2'b00}) begin
        errors++;
        $display("FAIL load%0d_bus: r=%b w=%b be=%b a=%h, want 1 0 %b %h", i, avm_read,
                 avm_write, avm_byteenable, avm_address, ld_be[i], {ld_addr[i][31:2], 2'b00});
      end
      step;
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'h80011234;
      step;
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'h0;
      step;
      checks++;
      if (rsp_valid !== 1'b1) begin
        errors++;
        $display("FAIL load%0d_latency: rsp_valid=%b at accept+4, want 1", i, rsp_valid);
      end
      step;
    end
  endtask

  logic        mis_wr[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0]  mis_size[4] = '{2'd2, 2'd1, 2'd3, 2'd2};
  logic [31:0] mis_addr[4] = '{32'h1002, 32'h2001, 32'h1000, 32'h2003};

  task automatic test_misaligned;
    for (int i = 0; i < 4; i++) begin
      send_cmd(mis_wr[i], mis_size[i], 1'b1, mis_addr[i], 32'h12345678, 32'h0, 1'b1, 1'b1);
      checks++;
      if (avm_write !== 1'b0 || avm_read !== 1'b0 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL mis%0d_c1: w=%b r=%b rv=%b, want 0 0 0", i, avm_write, avm_read, rsp_valid);
      end
      step;
      checks++;
      if (rsp_valid !== 1'b1 || avm_write !== 1'b0 || avm_read !== 1'b0) begin
        errors++;
        $display("FAIL mis%0d_c2: rv=%b w=%b r=%b, want 1 0 0", i, rsp_valid, avm_write, avm_read);
      end
      step;
    end
  endtask

  task automatic test_waitrequest;
    avm_waitrequest = 1'b1;
    send_cmd(1'b1, 2'd1, 1'b0, 32'h3006, 32'h0000BEEF, 32'h0, 1'b0, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (avm_write !== 1'b1 || avm_read !== 1'b0 || avm_byteenable !== 4'b1100 ||
          avm_address !== 32'h3004 || avm_writedata !== 32'hBEEFBEEF || cmd_ready !== 1'b0 ||
          rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold%0d: w=%b r=%b be=%b a=%h wd=%h rdy=%b rv=%b, want 1 0 1100 00003004 beefbeef 0 0",
                 c, avm_write, avm_read, avm_byteenable, avm_address, avm_writedata, cmd_ready,
                 rsp_valid);
      end
      step;
    end
    avm_waitrequest = 1'b0;
    checks++;
    if (avm_write !== 1'b1) begin
      errors++;
      $display("FAIL wait_release: w=%b, want 1", avm_write);
    end
    step;
    checks++;
    if (avm_write !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wait_done: w=%b rv=%b, want 0 0", avm_write, rsp_valid);
    end
    step;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_rsp: rsp_valid=%b, want 1", rsp_valid);
    end
    step;
  endtask

  task automatic test_reset_mid;
    bit bad;
    send_cmd(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b0, 1'b0);
    step;
    resetn = 1'b0;
    step;
    resetn = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1 || avm_read !== 1'b0 || avm_write !== 1'b0 || rsp_valid !== 1'b0 ||
        avm_address !== 32'h0 || avm_byteenable !== 4'h0) begin
      errors++;
      $display("FAIL midreset_state: rdy=%b r=%b w=%b rv=%b a=%h be=%h, want 1 0 0 0 0 0",
               cmd_ready, avm_read, avm_write, rsp_valid, avm_address, avm_byteenable);
    end
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'h12345678;
    step;
    avm_readdatavalid = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid !== 1'b0) bad = 1'b1;
      step;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midreset_late_rdv: rsp_valid seen=1, want no response");
    end
  endtask

  logic [1:0]  b2b_size[3] = '{2'd2, 2'd1, 2'd0};
  logic [31:0] b2b_addr[3] = '{32'h0010, 32'h0013, 32'h0012};
  int          b2b_lat[3]  = '{2, 1, 2};

  task automatic test_back_to_back;
    bit seen;
    int n;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b%0d_ready: got %b want 1", i, cmd_ready);
      end
      send_cmd(1'b1, b2b_size[i], 1'b0, b2b_addr[i], 32'h01020304, 32'h0, (i == 1), 1'b1);
      wait_rsp(10, seen, n);
      checks++;
      if (!seen || n != b2b_lat[i]) begin
        errors++;
        $display("FAIL b2b%0d_latency: seen=%b cycles=%0d, want seen=1 cycles=%0d", i, seen, n,
                 b2b_lat[i]);
      end
    end
    step;
  endtask

`ifdef AVM_TIMEOUT_EN
  task automatic test_timeout;
    bit seen;
    int n;
    send_cmd(1'b0, 2'd2, 1'b0, 32'h5000, 32'h0, 32'h0, 1'b1, 1'b1);
    wait_rsp(60, seen, n);
    checks++;
    if (!seen || n < 16 || n > 20 || avm_read !== 1'b0) begin
      errors++;
      $display("FAIL timeout: seen=%b cycles=%0d r=%b, want seen=1 cycles 16..20 r=0", seen, n,
               avm_read);
    end
    step;
  endtask
`else
  task automatic test_timeout;
    bit bad;
    bit seen;
    int n;
    send_cmd(1'b0, 2'd2, 1'b0, 32'h5000, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step;
      if (rsp_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL no_timeout_wait: response before readdatavalid, want none");
    end
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'hCAFEF00D;
    step;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
    n = 0;
    wait_rsp(10, seen, n);
    checks++;
    if (!seen || n != 1) begin
      errors++;
      $display("FAIL no_timeout_rsp: seen=%b cycles=%0d, want seen=1 cycles=1", seen, n);
    end
    step;
  endtask
`endif

  initial begin
    resetn            = 1'b0;
    cmd_valid         = 1'b0;
    cmd_write         = 1'b0;
    cmd_size          = 2'd0;
    cmd_signed        = 1'b0;
    cmd_addr          = 32'h0;
    cmd_wdata         = 32'h0;
    avm_readdata      = 32'h0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    test_reset;
    test_sw;
    test_sb;
    test_loads;
    test_misaligned;
    test_waitrequest;
    test_reset_mid;
    test_back_to_back;
    test_timeout;
    step;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: %0d responses outstanding, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
